// File: rtl/id_ex_operand_stage.sv
// ID/EX pipeline register and operand-resolution stage of the 16-bit core.
// Captures register-file read data and decode controls, applies write-back
// bypass at capture, forwards EX/MEM and WB results into the EX operands,
// and flags load-use hazards so the front end can hold IF/ID for a cycle.
module id_ex_operand_stage #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              stall,
    input  logic              flush,
    input  logic              id_valid,
    input  logic [ADDR_W-1:0] id_src1_addr,
    input  logic [ADDR_W-1:0] id_src2_addr,
    input  logic              id_use_src2,
    input  logic [DATA_W-1:0] rf_rdata1,
    input  logic [DATA_W-1:0] rf_rdata2,
    input  logic [ADDR_W-1:0] id_dst_addr,
    input  logic              id_we,
    input  logic              id_is_load,
    input  logic [DATA_W-1:0] id_imm,
    input  logic              id_use_imm,
    input  logic              exm_valid,
    input  logic              exm_we,
    input  logic [ADDR_W-1:0] exm_addr,
    input  logic [DATA_W-1:0] exm_data,
    input  logic              wb_we,
    input  logic [ADDR_W-1:0] wb_addr,
    input  logic [DATA_W-1:0] wb_data,
    output logic              ex_valid,
    output logic [DATA_W-1:0] ex_op1,
    output logic [DATA_W-1:0] ex_op2,
    output logic [ADDR_W-1:0] ex_dst_addr,
    output logic              ex_we,
    output logic              ex_is_load,
    output logic              load_use_hazard
);

    localparam logic [ADDR_W-1:0] R0 = {ADDR_W{1'b0}};
    localparam logic [DATA_W-1:0] ZERO = {DATA_W{1'b0}};

    // Stage registers and their next-state values
    logic              valid_q,   valid_d;
    logic              we_q,      we_d;
    logic              is_load_q, is_load_d;
    logic [ADDR_W-1:0] dst_q,     dst_d;
    logic [ADDR_W-1:0] src1_q,    src1_d;
    logic [ADDR_W-1:0] src2_q,    src2_d;
    logic [DATA_W-1:0] raw1_q,    raw1_d;
    logic [DATA_W-1:0] raw2_q,    raw2_d;
    logic [DATA_W-1:0] imm_q,     imm_d;
    logic              use_imm_q, use_imm_d;

    logic              hazard_s;

    // Value seen in ID for a source: R0 is zero, a same-edge WB write wins
    // over the register file (which still returns the old value this cycle).
    function automatic logic [DATA_W-1:0] id_bypass(
        input logic [ADDR_W-1:0] src,
        input logic [DATA_W-1:0] rdata,
        input logic              wb_we_a,
        input logic [ADDR_W-1:0] wb_addr_a,
        input logic [DATA_W-1:0] wb_data_a
    );
        logic [DATA_W-1:0] res;
        if (src == R0) begin
            res = ZERO;
        end else if (wb_we_a && (wb_addr_a == src)) begin
            res = wb_data_a;
        end else begin
            res = rdata;
        end
        return res;
    endfunction

    // EX operand resolution: youngest producer (EX/MEM) first, then WB.
    function automatic logic [DATA_W-1:0] ex_forward(
        input logic [ADDR_W-1:0] src,
        input logic [DATA_W-1:0] raw,
        input logic              exm_fwd_a,
        input logic [ADDR_W-1:0] exm_addr_a,
        input logic [DATA_W-1:0] exm_data_a,
        input logic              wb_we_a,
        input logic [ADDR_W-1:0] wb_addr_a,
        input logic [DATA_W-1:0] wb_data_a
    );
        logic [DATA_W-1:0] res;
        if (src == R0) begin
            res = ZERO;
        end else if (exm_fwd_a && (exm_addr_a == src)) begin
            res = exm_data_a;
        end else if (wb_we_a && (wb_addr_a == src)) begin
            res = wb_data_a;
        end else begin
            res = raw;
        end
        return res;
    endfunction

    assign ex_valid    = valid_q;
    assign ex_we       = we_q & valid_q;
    assign ex_is_load  = is_load_q & valid_q;
    assign ex_dst_addr = dst_q;

    // Load in EX whose result a following ID instruction needs; flush kills it
    always_comb begin
        hazard_s = 1'b0;
        if (flush) begin
            hazard_s = 1'b0;
        end else begin
            hazard_s = id_valid & ex_valid & ex_is_load & ex_we & (dst_q != R0) &
                       ((dst_q == id_src1_addr) | (id_use_src2 & (dst_q == id_src2_addr)));
        end
    end

    assign load_use_hazard = hazard_s;

    // Forward the freshest value of each source into the EX operands
    always_comb begin
        ex_op1 = ex_forward(src1_q, raw1_q, exm_valid & exm_we, exm_addr, exm_data,
                            wb_we, wb_addr, wb_data);
        if (use_imm_q) begin
            ex_op2 = imm_q;
        end else begin
            ex_op2 = ex_forward(src2_q, raw2_q, exm_valid & exm_we, exm_addr, exm_data,
                                wb_we, wb_addr, wb_data);
        end
    end

    // Next-state selection: flush > stall (with WB refresh) > bubble > capture
    always_comb begin
        valid_d   = valid_q;
        we_d      = we_q;
        is_load_d = is_load_q;
        dst_d     = dst_q;
        src1_d    = src1_q;
        src2_d    = src2_q;
        raw1_d    = raw1_q;
        raw2_d    = raw2_q;
        imm_d     = imm_q;
        use_imm_d = use_imm_q;
        if (flush) begin
            valid_d   = 1'b0;
            we_d      = 1'b0;
            is_load_d = 1'b0;
        end else if (stall) begin
            // A held instruction must not keep a value WB overwrites meanwhile
            if (wb_we && (wb_addr != R0) && (wb_addr == src1_q)) begin
                raw1_d = wb_data;
            end else begin
                raw1_d = raw1_q;
            end
            if (wb_we && (wb_addr != R0) && (wb_addr == src2_q)) begin
                raw2_d = wb_data;
            end else begin
                raw2_d = raw2_q;
            end
        end else if (hazard_s) begin
            valid_d   = 1'b0;
            we_d      = 1'b0;
            is_load_d = 1'b0;
        end else begin
            valid_d   = id_valid;
            we_d      = id_we;
            is_load_d = id_is_load;
            dst_d     = id_dst_addr;
            src1_d    = id_src1_addr;
            src2_d    = id_src2_addr;
            raw1_d    = id_bypass(id_src1_addr, rf_rdata1, wb_we, wb_addr, wb_data);
            raw2_d    = id_bypass(id_src2_addr, rf_rdata2, wb_we, wb_addr, wb_data);
            imm_d     = id_imm;
            use_imm_d = id_use_imm;
        end
    end

    // Stage register bank
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q   <= 1'b0;
            we_q      <= 1'b0;
            is_load_q <= 1'b0;
            dst_q     <= R0;
            src1_q    <= R0;
            src2_q    <= R0;
            raw1_q    <= ZERO;
            raw2_q    <= ZERO;
            imm_q     <= ZERO;
            use_imm_q <= 1'b0;
        end else begin
            valid_q   <= valid_d;
            we_q      <= we_d;
            is_load_q <= is_load_d;
            dst_q     <= dst_d;
            src1_q    <= src1_d;
            src2_q    <= src2_d;
            raw1_q    <= raw1_d;
            raw2_q    <= raw2_d;
            imm_q     <= imm_d;
            use_imm_q <= use_imm_d;
        end
    end

endmodule

// File: tb/tb_id_ex_operand_stage.sv
// Directed-vector bench for id_ex_operand_stage. Stimulus pushes expected
// outputs, tagged with the cycle they apply to, into a scoreboard queue; a
// monitor on the falling edge pops and compares them.
module tb_id_ex_operand_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        stall, flush, id_valid, id_use_src2, id_we, id_is_load, id_use_imm;
    logic [3:0]  id_src1_addr, id_src2_addr, id_dst_addr, exm_addr, wb_addr;
    logic [15:0] rf_rdata1, rf_rdata2, id_imm, exm_data, wb_data;
    logic        exm_valid, exm_we, wb_we;
    logic        ex_valid, ex_we, ex_is_load, load_use_hazard;
    logic [15:0] ex_op1, ex_op2;
    logic [3:0]  ex_dst_addr;

    id_ex_operand_stage #(.DATA_W(16), .ADDR_W(4)) dut (
        .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush),
        .id_valid(id_valid), .id_src1_addr(id_src1_addr), .id_src2_addr(id_src2_addr),
        .id_use_src2(id_use_src2), .rf_rdata1(rf_rdata1), .rf_rdata2(rf_rdata2),
        .id_dst_addr(id_dst_addr), .id_we(id_we), .id_is_load(id_is_load),
        .id_imm(id_imm), .id_use_imm(id_use_imm),
        .exm_valid(exm_valid), .exm_we(exm_we), .exm_addr(exm_addr), .exm_data(exm_data),
        .wb_we(wb_we), .wb_addr(wb_addr), .wb_data(wb_data),
        .ex_valid(ex_valid), .ex_op1(ex_op1), .ex_op2(ex_op2), .ex_dst_addr(ex_dst_addr),
        .ex_we(ex_we), .ex_is_load(ex_is_load), .load_use_hazard(load_use_hazard)
    );

    always #5 clk = ~clk;

    // mask bits: 0 ex_valid, 1 ex_op1, 2 ex_op2, 3 load_use_hazard, 4 ex_is_load
    typedef struct {
        string       name;
        int          cyc;
        logic [4:0]  mask;
        logic        v;
        logic [15:0] o1;
        logic [15:0] o2;
        logic        h;
        logic        ld;
    } exp_t;

    exp_t sb_q[$];
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    logic done = 1'b0;
    logic final_seen = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string n, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", n, act, exp, cyc);
        end
    endtask

    // Scoreboard monitor: compare every entry due this cycle
    always @(negedge clk) begin
        exp_t e;
        while (sb_q.size() > 0 && sb_q[0].cyc <= cyc) begin
            e = sb_q.pop_front();
            if (e.cyc < cyc) begin
                chk({e.name, "_stale"}, 16'(e.cyc), 16'(cyc));
            end else begin
                if (e.mask[0]) chk({e.name, "_valid"}, {15'd0, ex_valid}, {15'd0, e.v});
                if (e.mask[1]) chk({e.name, "_op1"}, ex_op1, e.o1);
                if (e.mask[2]) chk({e.name, "_op2"}, ex_op2, e.o2);
                if (e.mask[3]) chk({e.name, "_hazard"}, {15'd0, load_use_hazard}, {15'd0, e.h});
                if (e.mask[4]) chk({e.name, "_is_load"}, {15'd0, ex_is_load}, {15'd0, e.ld});
            end
        end
        if (done && !final_seen) begin
            final_seen <= 1'b1;
            chk("scoreboard_drained", 16'(sb_q.size()), 16'd0);
        end
    end

    task automatic push_exp(input string n, input logic [4:0] m, input logic v,
                            input logic [15:0] o1, input logic [15:0] o2,
                            input logic h, input logic ld);
        exp_t e;
        e.name = n; e.cyc = cyc; e.mask = m;
        e.v = v; e.o1 = o1; e.o2 = o2; e.h = h; e.ld = ld;
        sb_q.push_back(e);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_in();
        stall = 1'b0; flush = 1'b0; id_valid = 1'b0; id_use_src2 = 1'b0;
        id_we = 1'b0; id_is_load = 1'b0; id_use_imm = 1'b0;
        id_src1_addr = 4'd0; id_src2_addr = 4'd0; id_dst_addr = 4'd0;
        rf_rdata1 = 16'h0000; rf_rdata2 = 16'h0000; id_imm = 16'h0000;
        exm_valid = 1'b0; exm_we = 1'b0; exm_addr = 4'd0; exm_data = 16'h0000;
        wb_we = 1'b0; wb_addr = 4'd0; wb_data = 16'h0000;
    endtask

    initial begin
        rst_n = 1'b0;
        clear_in();
        id_valid = 1'b1; id_src1_addr = 4'd3; rf_rdata1 = 16'h1234;
        // T0: reset held with a valid instruction presented
        tick();
        push_exp("reset", 5'b11111, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0);
        // T1: release; present instruction reading R3
        tick();
        rst_n = 1'b1;
        clear_in();
        id_valid = 1'b1; id_src1_addr = 4'd3; rf_rdata1 = 16'h1234;
        id_src2_addr = 4'd0; rf_rdata2 = 16'hFFFF; id_we = 1'b1; id_dst_addr = 4'd3;
        push_exp("post_reset", 5'b01001, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0);
        // T2: R3 captured; present ID bypass case (WB writes R5 same edge)
        tick();
        clear_in();
        id_valid = 1'b1; id_src1_addr = 4'd5; rf_rdata1 = 16'h0000;
        id_src2_addr = 4'd0; rf_rdata2 = 16'hFFFF;
        wb_we = 1'b1; wb_addr = 4'd5; wb_data = 16'hBEEF;
        push_exp("first_capture", 5'b01111, 1'b1, 16'h1234, 16'h0000, 1'b0, 1'b0);
        // T3: bypassed value in EX; EX/MEM targets R0 while src2 is R0
        tick();
        clear_in();
        id_valid = 1'b1; id_src1_addr = 4'd7; rf_rdata1 = 16'h0033;
        id_src2_addr = 4'd0; rf_rdata2 = 16'hFFFF; id_we = 1'b1; id_dst_addr = 4'd9;
        exm_valid = 1'b1; exm_we = 1'b1; exm_addr = 4'd0; exm_data = 16'h5555;
        push_exp("id_bypass", 5'b00010, 1'b0, 16'hBEEF, 16'h0000, 1'b0, 1'b0);
        push_exp("r0_op2", 5'b00100, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0);
        // T4: EX/MEM and WB both target R7, EX/MEM wins
        tick();
        clear_in();
        stall = 1'b1;
        exm_valid = 1'b1; exm_we = 1'b1; exm_addr = 4'd7; exm_data = 16'h0011;
        wb_we = 1'b1; wb_addr = 4'd7; wb_data = 16'h0022;
        push_exp("exm_priority", 5'b00111, 1'b1, 16'h0011, 16'h0000, 1'b0, 1'b0);
        // T5: stall refresh captured WB 0022; EX/MEM invalid must not forward
        tick();
        clear_in();
        stall = 1'b1;
        exm_we = 1'b1; exm_addr = 4'd7; exm_data = 16'h0011;
        push_exp("stall_refresh", 5'b00011, 1'b1, 16'h0022, 16'h0000, 1'b0, 1'b0);
        // T6: WB forward of a new value to R7
        tick();
        clear_in();
        stall = 1'b1;
        exm_we = 1'b1; exm_addr = 4'd7; exm_data = 16'h0011;
        wb_we = 1'b1; wb_addr = 4'd7; wb_data = 16'h0044;
        push_exp("wb_forward", 5'b00011, 1'b1, 16'h0044, 16'h0000, 1'b0, 1'b0);
        // T7: stall released; capture a load to R4
        tick();
        clear_in();
        id_valid = 1'b1; id_is_load = 1'b1; id_we = 1'b1; id_dst_addr = 4'd4;
        id_src1_addr = 4'd1; rf_rdata1 = 16'h0101;
        id_src2_addr = 4'd2; rf_rdata2 = 16'h0202; id_use_src2 = 1'b1;
        push_exp("held_refreshed", 5'b01011, 1'b1, 16'h0044, 16'h0000, 1'b0, 1'b0);
        // T8: load in EX; consumer reads R4 only via src2, src2 unused
        tick();
        clear_in();
        stall = 1'b1;
        id_valid = 1'b1; id_we = 1'b1; id_dst_addr = 4'd6;
        id_src1_addr = 4'd1; rf_rdata1 = 16'h0111;
        id_src2_addr = 4'd4; rf_rdata2 = 16'h0222; id_use_src2 = 1'b0;
        push_exp("no_haz_src2_unused", 5'b11111, 1'b1, 16'h0101, 16'h0202, 1'b0, 1'b1);
        // T9: src2 used -> hazard, even while stalled
        tick();
        id_use_src2 = 1'b1;
        push_exp("haz_during_stall", 5'b11001, 1'b1, 16'h0000, 16'h0000, 1'b1, 1'b1);
        // T10: stall released, hazard inserts a bubble at this edge
        tick();
        stall = 1'b0;
        push_exp("haz_load_use", 5'b01001, 1'b1, 16'h0000, 16'h0000, 1'b1, 1'b0);
        // T11: bubble in EX
        tick();
        push_exp("bubble", 5'b11001, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0);
        // T12: consumer captured; start stall
        tick();
        clear_in();
        stall = 1'b1;
        push_exp("after_bubble", 5'b10111, 1'b1, 16'h0111, 16'h0222, 1'b0, 1'b0);
        // T13: WB writes R1 mid-stall
        tick();
        wb_we = 1'b1; wb_addr = 4'd1; wb_data = 16'hA5A5;
        push_exp("stall_wb_fwd", 5'b00011, 1'b1, 16'hA5A5, 16'h0000, 1'b0, 1'b0);
        // T14: WB gone, held operand refreshed
        tick();
        wb_we = 1'b0;
        push_exp("stall_held", 5'b00111, 1'b1, 16'hA5A5, 16'h0222, 1'b0, 1'b0);
        // T15: stall and flush together
        tick();
        flush = 1'b1;
        push_exp("stall_flush_pre", 5'b00001, 1'b1, 16'h0000, 16'h0000, 1'b0, 1'b0);
        // T16: flushed; capture a load with an immediate operand
        tick();
        clear_in();
        id_valid = 1'b1; id_is_load = 1'b1; id_we = 1'b1; id_dst_addr = 4'd8;
        id_src1_addr = 4'd3; rf_rdata1 = 16'h1357;
        id_src2_addr = 4'd2; rf_rdata2 = 16'h0BAD;
        id_use_imm = 1'b1; id_imm = 16'h7FFE;
        push_exp("flushed", 5'b10001, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0);
        // T17: immediate ignores forwarding; flush masks a real hazard
        tick();
        clear_in();
        flush = 1'b1;
        id_valid = 1'b1; id_src1_addr = 4'd8;
        exm_valid = 1'b1; exm_we = 1'b1; exm_addr = 4'd2; exm_data = 16'hCAFE;
        wb_we = 1'b1; wb_addr = 4'd2; wb_data = 16'hDEAD;
        push_exp("imm_flush_haz", 5'b11111, 1'b1, 16'h1357, 16'h7FFE, 1'b0, 1'b1);
        // T18: flushed; capture a load to R5
        tick();
        clear_in();
        id_valid = 1'b1; id_is_load = 1'b1; id_we = 1'b1; id_dst_addr = 4'd5;
        id_src1_addr = 4'd5;
        push_exp("flushed_load", 5'b11001, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0);
        // T19: stalled consumer of R5 raises hazard
        tick();
        clear_in();
        stall = 1'b1; id_valid = 1'b1; id_src1_addr = 4'd5;
        push_exp("pre_reset_haz", 5'b11001, 1'b1, 16'h0000, 16'h0000, 1'b1, 1'b1);
        // T20: asynchronous reset mid-stall, mid-hazard
        tick();
        rst_n = 1'b0;
        push_exp("mid_reset", 5'b11111, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0);
        // T21: release reset, nothing pending
        tick();
        rst_n = 1'b1;
        clear_in();
        push_exp("after_reset", 5'b11001, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0);
        tick();
        tick();
        done = 1'b1;
        tick();
        tick();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
